// File: rtl/cu_pkg.sv
// Shared encodings, the D/E control word and the MUL/DIV sequencer state type
// for the pipelined RV32 control unit.
package cu_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MEXT = 7'h01;

    localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4,  ALU_SLT  = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8,  ALU_SRA  = 4'd9, ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100;
    localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_MD = 2'b11;
    localparam logic [1:0] MW_NONE = 2'b00, MW_SB = 2'b01, MW_SH = 2'b10, MW_SW = 2'b11;
    localparam logic [2:0] RW_NONE = 3'b000, RW_WORD = 3'b001, RW_LB = 3'b010, RW_LH = 3'b011;
    localparam logic [2:0] RW_LBU = 3'b100, RW_LHU = 3'b101;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       md;
        logic [1:0] result_src;
        logic [1:0] mem_write;
        logic [2:0] reg_write;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic       jump;
        logic       branch;
        logic [2:0] funct3;
    } ctrl_t;

    // Register/immediate ALU op selected by funct3 (SUB/SRA picked separately by funct7b5)
    function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/control_unit_pipe_if.sv
// D-stage inputs and E-stage control outputs of the control unit.
interface control_unit_pipe_if #(parameter int ALU_CTRL_W = 4);
    logic [31:0]           InstrD;
    logic                  ValidD, StallE, FlushE;
    logic [2:0]            ImmSrcD;
    logic                  ValidE;
    logic [1:0]            ResultSrcE, MemWriteE;
    logic [2:0]            RegWriteE;
    logic                  ALUSrcE;
    logic [ALU_CTRL_W-1:0] ALUControlE;
    logic                  JumpE, BranchE;
    logic [2:0]            Funct3E;
    logic                  IllegalE, md_stall, md_done;

    modport master (output InstrD, ValidD, StallE, FlushE,
                    input  ImmSrcD, ValidE, ResultSrcE, MemWriteE, RegWriteE, ALUSrcE,
                           ALUControlE, JumpE, BranchE, Funct3E, IllegalE, md_stall, md_done);
    modport slave  (input  InstrD, ValidD, StallE, FlushE,
                    output ImmSrcD, ValidE, ResultSrcE, MemWriteE, RegWriteE, ALUSrcE,
                           ALUControlE, JumpE, BranchE, Funct3E, IllegalE, md_stall, md_done);
endinterface

// File: rtl/cu_decode_comb.sv
// Pure combinational RV32 decoder: instruction -> control word + immediate format.
// CU_MEXT_EN adds the M extension (funct7=0x01 on OP), otherwise those encodings are illegal.
module cu_decode_comb
    import cu_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [2:0]  imm_src
);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       bad;
    logic       fields_unused;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign fields_unused = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl       = '0;
        ctrl.valid = 1'b1;
        imm_src    = IMM_I;
        bad        = 1'b0;
        case (op)
            OP_LUI:   begin imm_src = IMM_U; ctrl.alu_src = 1'b1; ctrl.alu_ctrl = ALU_PASSB; ctrl.reg_write = RW_WORD; end
            OP_AUIPC: begin imm_src = IMM_U; ctrl.alu_src = 1'b1; ctrl.reg_write = RW_WORD; end
            OP_JAL:   begin imm_src = IMM_J; ctrl.jump = 1'b1; ctrl.reg_write = RW_WORD; ctrl.result_src = RES_PC4; end
            OP_JALR:  begin
                ctrl.jump = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = RW_WORD; ctrl.result_src = RES_PC4;
            end
            OP_BRANCH: begin
                imm_src = IMM_B; ctrl.branch = 1'b1; ctrl.alu_ctrl = ALU_SUB; ctrl.funct3 = f3;
                bad = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OP_LOAD: begin
                ctrl.alu_src = 1'b1; ctrl.result_src = RES_MEM;
                case (f3)
                    3'd0:    ctrl.reg_write = RW_LB;
                    3'd1:    ctrl.reg_write = RW_LH;
                    3'd2:    ctrl.reg_write = RW_WORD;
                    3'd4:    ctrl.reg_write = RW_LBU;
                    3'd5:    ctrl.reg_write = RW_LHU;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                imm_src = IMM_S; ctrl.alu_src = 1'b1;
                ctrl.mem_write = f3[1:0] + 2'd1;
                bad = (f3 >= 3'd3);
            end
            OP_IMM: begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = RW_WORD; ctrl.alu_ctrl = alu_of_f3(f3);
                // only the shift forms constrain funct7; elsewhere those bits are immediate
                if (f3 == 3'd1 && f7 != F7_BASE) bad = 1'b1;
                if (f3 == 3'd5) begin
                    if (f7 == F7_ALT) ctrl.alu_ctrl = ALU_SRA;
                    else if (f7 != F7_BASE) bad = 1'b1;
                end
            end
            OP_OP: begin
                ctrl.reg_write = RW_WORD;
                if (f7 == F7_MEXT) begin
`ifdef CU_MEXT_EN
                    ctrl.result_src = RES_MD; ctrl.funct3 = f3; ctrl.md = 1'b1;
`else
                    bad = 1'b1;
`endif
                end else if (f7 == F7_BASE) ctrl.alu_ctrl = alu_of_f3(f3);
                else if (f7 == F7_ALT && f3 == 3'd0) ctrl.alu_ctrl = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'd5) ctrl.alu_ctrl = ALU_SRA;
                else bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            ctrl         = '0;
            ctrl.valid   = 1'b1;
            ctrl.illegal = 1'b1;
            imm_src      = IMM_I;
        end
    end
endmodule

// File: rtl/control_unit_pipe.sv
// RV32 control unit: D-stage decode, D/E control register with stall/flush and the
// MUL/DIV occupancy sequencer in E (built only when CU_MEXT_EN is defined).
module control_unit_pipe
    import cu_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int MUL_LAT    = 2,
    parameter int DIV_LAT    = 34
) (
    input  logic                clk,
    input  logic                rst,
    control_unit_pipe_if.slave  bus
);
    ctrl_t dec, e_q;
    logic  md_stall, md_done;

    cu_decode_comb u_dec (.instr(bus.InstrD), .ctrl(dec), .imm_src(bus.ImmSrcD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          e_q <= '0;
        else if (bus.FlushE)              e_q <= '0;
        else if (!(bus.StallE | md_stall)) e_q <= bus.ValidD ? dec : '0;
    end

`ifdef CU_MEXT_EN
    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    md_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             rdy, rdy_d;
    logic             md_e;
    int               lat;

    assign md_e = e_q.valid & e_q.md;
    assign lat  = e_q.funct3[2] ? DIV_LAT : MUL_LAT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            rdy   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            rdy   <= rdy_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        rdy_d    = rdy;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state)
            MD_IDLE: if (md_e && !rdy) begin
                if (lat > 1) begin
                    md_stall = 1'b1;
                    cnt_d    = CNT_W'(lat - 2);
                    state_d  = MD_BUSY;
                end else begin
                    md_done = 1'b1;
                end
            end
            MD_BUSY: if (cnt != '0) begin
                md_stall = 1'b1;
                cnt_d    = cnt - 1'b1;
            end else begin
                md_done = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        // a finished op still held by StallE must not start again
        if (md_done && bus.StallE) rdy_d = 1'b1;
        if (!bus.StallE && !md_stall) rdy_d = 1'b0;
        if (bus.FlushE) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
            rdy_d   = 1'b0;
            md_done = 1'b0;
        end
    end
`else
    logic md_unused;
    assign md_unused = e_q.md ^ (MUL_LAT > 0) ^ (DIV_LAT > 0);
    assign md_stall  = 1'b0;
    assign md_done   = 1'b0;
`endif

    assign bus.ValidE      = e_q.valid;
    assign bus.ResultSrcE  = e_q.result_src;
    assign bus.MemWriteE   = e_q.mem_write;
    assign bus.RegWriteE   = e_q.reg_write;
    assign bus.ALUSrcE     = e_q.alu_src;
    assign bus.ALUControlE = ALU_CTRL_W'(e_q.alu_ctrl);
    assign bus.JumpE       = e_q.jump;
    assign bus.BranchE     = e_q.branch;
    assign bus.Funct3E     = e_q.funct3;
    assign bus.IllegalE    = e_q.illegal;
    assign bus.md_stall    = md_stall;
    assign bus.md_done     = md_done;
endmodule
